// File: rtl/hb_boot_pkg.sv
// Shared types for the boot copy sequencer: FSM state encoding and the
// memory strobe bundle with its per-state constant words.
package hb_boot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ROM_RD,
        RAM_WR,
        RAM_REL,
        V_ROM,
        V_RAM,
        DONE,
        ERR
    } state_t;

    typedef struct packed {
        logic rom_ce_bar;
        logic rom_oe_bar;
        logic ram_cs_bar;
        logic ram_we_bar;
        logic ram_oe_bar;
        logic ram_drive;
    } strobe_t;

    localparam strobe_t STB_IDLE    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam strobe_t STB_ROM_RD  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam strobe_t STB_RAM_WR  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam strobe_t STB_RAM_REL = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    localparam strobe_t STB_V_RAM   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    // A held ROM read parks the bus with every strobe released.
    function automatic strobe_t strobes_for(input state_t st, input logic held);
        strobe_t s;
        s = STB_IDLE;
        case (st)
            ROM_RD, V_ROM: s = held ? STB_IDLE : STB_ROM_RD;
            RAM_WR:        s = STB_RAM_WR;
            RAM_REL:       s = STB_RAM_REL;
            V_RAM:         s = STB_V_RAM;
            default:       s = STB_IDLE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/boot_byte_cnt.sv
// Byte index counter for the copy and verify passes, with a terminal
// compare against LENGTH-1 so the index never has to wrap.
module boot_byte_cnt
    import hb_boot_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int LENGTH = 4096
) (
    input  logic              clk,
    input  logic              rst_bar,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] idx,
    output logic [ADDR_W-1:0] idx_nxt,
    output logic              last
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LENGTH - 1);

    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] idx_d;

    always_comb begin
        idx_d = idx_q;
        if (clr) begin
            idx_d = '0;
        end else if (inc) begin
            idx_d = idx_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_bar) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx     = idx_q;
    assign idx_nxt = idx_d;
    assign last    = (idx_q == LAST_IDX);

endmodule

// File: rtl/boot_copy_ctrl.sv
// Boot sequencer: copies the EEPROM image into RAM, verifies it by read-back
// and only then releases the CPU from reset. Every output is a flop.
module boot_copy_ctrl
    import hb_boot_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int LENGTH    = 4096,
    parameter int WE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_bar,
    input  logic              start,
    input  logic              hold,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_ce_bar,
    output logic              rom_oe_bar,
    input  logic [7:0]        rom_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_cs_bar,
    output logic              ram_we_bar,
    output logic              ram_oe_bar,
    output logic [7:0]        ram_wdata,
    output logic              ram_drive,
    input  logic [7:0]        ram_rdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr,
    output logic              cpu_rst_bar
);

    localparam logic [1:0] WE_LAST = 2'(WE_CYCLES - 1);

    state_t            state_q, state_d;
    logic              held_q, held_d;
    logic              start_q, start_d;
    logic [7:0]        data_q, data_d;
    logic [1:0]        we_cnt_q, we_cnt_d;
    strobe_t           strobe_q, strobe_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              cpu_rst_bar_q, cpu_rst_bar_d;

    logic              cnt_clr;
    logic              cnt_inc;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_nxt;
    logic              idx_last;

    boot_byte_cnt #(
        .ADDR_W (ADDR_W),
        .LENGTH (LENGTH)
    ) u_cnt (
        .clk     (clk),
        .rst_bar (rst_bar),
        .clr     (cnt_clr),
        .inc     (cnt_inc),
        .idx     (idx),
        .idx_nxt (idx_nxt),
        .last    (idx_last)
    );

    // Outputs are decoded from the next state so the registered strobes
    // line up with the state they belong to.
    always_comb begin
        state_d    = state_q;
        held_d     = held_q;
        start_d    = start;
        data_d     = data_q;
        we_cnt_d   = we_cnt_q;
        err_addr_d = err_addr_q;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start_q) begin
                    state_d    = ROM_RD;
                    held_d     = hold;
                    err_addr_d = '0;
                    cnt_clr    = 1'b1;
                end
            end
            ROM_RD: begin
                if (held_q) begin
                    held_d = hold;
                end else begin
                    data_d   = rom_data;
                    we_cnt_d = 2'd0;
                    state_d  = RAM_WR;
                end
            end
            RAM_WR: begin
                if (we_cnt_q == WE_LAST) begin
                    state_d = RAM_REL;
                end else begin
                    we_cnt_d = we_cnt_q + 2'd1;
                end
            end
            RAM_REL: begin
                held_d = hold;
                if (idx_last) begin
                    cnt_clr = 1'b1;
                    state_d = V_ROM;
                end else begin
                    cnt_inc = 1'b1;
                    state_d = ROM_RD;
                end
            end
            V_ROM: begin
                if (held_q) begin
                    held_d = hold;
                end else begin
                    data_d  = rom_data;
                    state_d = V_RAM;
                end
            end
            V_RAM: begin
                if (ram_rdata != data_q) begin
                    err_addr_d = idx;
                    state_d    = ERR;
                end else if (idx_last) begin
                    state_d = DONE;
                end else begin
                    cnt_inc = 1'b1;
                    held_d  = hold;
                    state_d = V_ROM;
                end
            end
            default: state_d = IDLE;
        endcase

        strobe_d   = strobes_for(state_d, held_d);
        rom_addr_d = rom_addr_q;
        ram_addr_d = ram_addr_q;
        if (state_d == ROM_RD || state_d == V_ROM) begin
            rom_addr_d = idx_nxt;
            ram_addr_d = idx_nxt;
        end
        busy_d        = !(state_d == IDLE || state_d == DONE || state_d == ERR);
        done_d        = (state_d == DONE);
        err_d         = (state_d == ERR);
        cpu_rst_bar_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_bar) begin
            state_q       <= IDLE;
            held_q        <= 1'b0;
            start_q       <= 1'b0;
            data_q        <= 8'h00;
            we_cnt_q      <= 2'd0;
            strobe_q      <= STB_IDLE;
            rom_addr_q    <= '0;
            ram_addr_q    <= '0;
            err_addr_q    <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            cpu_rst_bar_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            held_q        <= held_d;
            start_q       <= start_d;
            data_q        <= data_d;
            we_cnt_q      <= we_cnt_d;
            strobe_q      <= strobe_d;
            rom_addr_q    <= rom_addr_d;
            ram_addr_q    <= ram_addr_d;
            err_addr_q    <= err_addr_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
            cpu_rst_bar_q <= cpu_rst_bar_d;
        end
    end

    assign rom_addr    = rom_addr_q;
    assign rom_ce_bar  = strobe_q.rom_ce_bar;
    assign rom_oe_bar  = strobe_q.rom_oe_bar;
    assign ram_addr    = ram_addr_q;
    assign ram_cs_bar  = strobe_q.ram_cs_bar;
    assign ram_we_bar  = strobe_q.ram_we_bar;
    assign ram_oe_bar  = strobe_q.ram_oe_bar;
    assign ram_drive   = strobe_q.ram_drive;
    assign ram_wdata   = data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign err_addr    = err_addr_q;
    assign cpu_rst_bar = cpu_rst_bar_q;

endmodule

// File: doc/boot_copy_ctrl.md
# boot_copy_ctrl

Boot-time sequencer that owns the program-store EEPROM and the cy7c199 RAM bus from reset until the program image is resident in RAM. It then releases the CPU core. It copies `LENGTH` bytes from EEPROM address 0.. into RAM address 0.., then runs a read-back verify pass, and raises `done` (or `err`). It holds `cpu_rst_bar` low throughout, so phase counter, PC and the `bootloader_done` path never see a partial image.

## Interface
- `ADDR_W`, 12: EEPROM/RAM address width.
- `LENGTH`, 4096: bytes to copy. Range 1..2^ADDR_W.
- `WE_CYCLES`, 1: RAM `we_bar` low width in clocks. Range 1..4.
- `clk` in 1: single system clock, all logic on rising edge.
- `rst_bar` in 1: reset, synchronous, active-low.
- `start` in 1: begin copy. Level-sampled; accepted only in IDLE, DONE or ERR.
- `hold` in 1: pause request. Honoured only at byte boundaries.
- `rom_addr` out ADDR_W: EEPROM address.
- `rom_ce_bar`, `rom_oe_bar` out 1: EEPROM strobes.
- `rom_data` in 8: EEPROM data.
- `ram_addr` out ADDR_W: RAM address.
- `ram_cs_bar`, `ram_we_bar`, `ram_oe_bar` out 1: RAM strobes.
- `ram_wdata` out 8: RAM write data. The driver is enabled only while `ram_drive` is high.
- `ram_drive` out 1: databus output enable for `ram_wdata`.
- `ram_rdata` in 8: RAM read data.
- `busy` out 1: copy or verify in progress.
- `done` out 1: image copied and verified. Sticky until next start or reset.
- `err` out 1: verify mismatch. Sticky until next start or reset.
- `err_addr` out ADDR_W: address of first mismatch.
- `cpu_rst_bar` out 1: CPU reset. High only in DONE.

## Operation
- States: IDLE, ROM_RD, RAM_WR, RAM_REL, V_ROM, V_RAM, DONE, ERR. Reset state is IDLE.
- Reset values:
  - All `*_bar` strobes are 1, `cpu_rst_bar` is 0.
  - `rom_addr`, `ram_addr` and `err_addr` are 0.
  - `ram_wdata` is 0.
  - `ram_drive`, `busy`, `done` and `err` are 0.
- IDLE/DONE/ERR + `start`: go to ROM_RD. Clear index, `done`, `err`, `err_addr`. Drive `cpu_rst_bar` low.
- ROM_RD, 1 clock:
  - `rom_ce_bar` and `rom_oe_bar` are 0, `rom_addr` = index.
  - The byte is latched into the data register at the exiting edge.
- RAM_WR, WE_CYCLES clocks:
  - `ram_cs_bar` and `ram_we_bar` are 0, `ram_drive` is 1, `ram_addr` = index.
- RAM_REL, 1 clock:
  - `ram_we_bar` is 1; `ram_cs_bar`, `ram_drive` and data are held, for hold time.
  - If index = LENGTH-1, go to V_ROM with index 0. Otherwise increment the index and go to ROM_RD.
- V_ROM, 1 clock: same as ROM_RD; latch the expected byte.
- V_RAM, 1 clock: `ram_cs_bar` and `ram_oe_bar` are 0, `ram_drive` is 0. Compare `ram_rdata` with the expected byte at the exiting edge.
  - Mismatch: go to ERR, capture `err_addr` = index.
  - Match at last index: go to DONE.
  - Otherwise increment the index and go to V_ROM.
- `hold`: sampled on entry to ROM_RD or V_ROM. While high, the FSM stays there with all strobes deasserted and the address held; `busy` stays 1. The pass resumes on the first cycle `hold` is low.
- `start` while `busy`: ignored.
- DONE: `cpu_rst_bar` is 1, `done` is 1. ERR: `cpu_rst_bar` is 0, `err` is 1.
- Arithmetic:
  - The index is ADDR_W bits and is compared to LENGTH-1, so it never overflows.
  - With LENGTH = 2^ADDR_W the final index is all-ones and no wrap occurs.

## Timing
- All outputs are registered (Moore). No combinational path from inputs to outputs.
- Count edge 0 as the edge sampling `start`.
  - Copy: (2+WE_CYCLES) clocks per byte.
  - Verify: 2 clocks per byte.
  - With no hold, `done` and `cpu_rst_bar` rise at edge (4+WE_CYCLES)·LENGTH + 1.
  - `busy` is 1 from edge 1 until that edge.
- `ram_we_bar` never falls in the same cycle that `ram_addr` changes. Address is stable one cycle before WE and one cycle after.
- `ram_drive` and `ram_oe_bar` are never low/high together. V_RAM always has `ram_drive` = 0.
- Reset mid-operation: the next edge forces reset values. `ram_we_bar` goes to 1 immediately; a partially written byte is acceptable.

## Structure
- Shared package `hb_boot_pkg`: state enum and strobe-bundle constants (IDLE strobe word).
- One sub-module `boot_byte_cnt`: ADDR_W index counter with clear, increment and a `last` compare against LENGTH-1.
- All remaining logic (FSM, data latch, compare, outputs) lives in `boot_copy_ctrl`.

## Test plan
- LENGTH=4, WE_CYCLES=1, ROM = {0x12,0x34,0x56,0x78}, pulse `start` → RAM holds the image, `done` rises at edge 21, `err` = 0, `cpu_rst_bar` goes high with `done`.
- WE_CYCLES=3, LENGTH=2 → `ram_we_bar` low exactly 3 clocks per byte, address stable ±1 clock around it, `done` at edge 15.
- RAM model corrupts address 2 (returns 0xFF) → `err` = 1, `err_addr` = 2, `cpu_rst_bar` stays 0, `done` = 0.
- `hold` high for 5 clocks while index = 1 → completion delayed by exactly 5 clocks; no strobes active during hold.
- `rst_bar` low during RAM_WR of byte 3 → next edge: `ram_we_bar` = 1, `busy` = 0, `cpu_rst_bar` = 0. A re-`start` then completes normally.
- LENGTH=4096 → last address 0xFFF is written, index does not wrap, `done` at edge 20481. `start` during `busy` has no effect.
